// File: rtl/fp16_mul_pkg.sv
// Shared FP16 definitions for the multiplier slice.
// Contents: format widths, bias, canonical encodings, field-extract helpers and a
// 22-bit leading-zero counter for product normalisation.
package fp16_mul_pkg;

  localparam int unsigned FP16_WIDTH = 16;
  localparam int unsigned EXP_W      = 5;
  localparam int unsigned MAN_W      = 10;
  localparam int unsigned BIAS       = 15;

  localparam logic [FP16_WIDTH-1:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [FP16_WIDTH-1:0] FP16_NEG_ZERO = 16'h8000;
  localparam logic [FP16_WIDTH-1:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [FP16_WIDTH-1:0] FP16_NEG_INF  = 16'hFC00;
  localparam logic [FP16_WIDTH-1:0] FP16_QNAN     = 16'h7E00;

  localparam logic signed [7:0] BIAS_S = 8'sd15;

  function automatic logic fp16_sign(input logic [FP16_WIDTH-1:0] v);
    return v[FP16_WIDTH-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp16_exp(input logic [FP16_WIDTH-1:0] v);
    return v[MAN_W +: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp16_man(input logic [FP16_WIDTH-1:0] v);
    return v[MAN_W-1:0];
  endfunction

  // Leading-zero count of a 22-bit product; returns 22 for an all-zero input.
  function automatic logic [4:0] lzc22(input logic [21:0] v);
    logic [4:0] n;
    n = 5'd22;
    for (int i = 0; i < 22; i++) begin
      if (v[i]) n = 5'(21 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_mul_if.sv
// Operand/result bundle for fp16_mul.
// master: drives in_valid/a/b, observes out_valid/y/flags.
// slave : the multiplier side.
interface fp16_mul_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] y;
  logic        flag_inv;
  logic        flag_ovf;
  logic        flag_unf;

  modport master (
    output in_valid, a, b,
    input  out_valid, y, flag_inv, flag_ovf, flag_unf
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, y, flag_inv, flag_ovf, flag_unf
  );
endinterface

// File: rtl/fp16_mul_round_pack.sv
// Combinational round-to-nearest-even and pack for FP16 results.
// Ports:
//   sign_i   result sign
//   exp_i    signed biased exponent of the normalised significand
//   sig_i    13-bit significand: [12] hidden one, [11:2] mantissa, [1] guard, [0] round
//   sticky_i OR of all lower product bits
//   y_o      packed FP16 result; ovf_o overflow to Inf; unf_o tiny and inexact
// Macro FP16_MUL_DENORM_EN: defined -> gradual underflow, undefined -> flush to zero.
module fp16_round_pack
  import fp16_mul_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [7:0] exp_i,
  input  logic [12:0]       sig_i,
  input  logic              sticky_i,
  output logic [15:0]       y_o,
  output logic              ovf_o,
  output logic              unf_o
);

  logic              inc;
  logic [11:0]       rnd;
  logic signed [7:0] exp_r;
  logic [9:0]        man_r;
`ifdef FP16_MUL_DENORM_EN
  logic signed [7:0] shamt;
  logic [12:0]       sh;
  logic              lost;
  logic              dg, dr, ds;
  logic              dinc;
  logic [11:0]       drnd;
`endif

  always_comb begin
    y_o   = '0;
    ovf_o = 1'b0;
    unf_o = 1'b0;

    // Normal-range rounding at the 10-bit mantissa position.
    inc   = sig_i[1] & (sig_i[0] | sticky_i | sig_i[2]);
    rnd   = {1'b0, sig_i[12:2]} + {11'b0, inc};
    exp_r = exp_i + $signed({7'b0, rnd[11]});
    man_r = rnd[11] ? rnd[10:1] : rnd[9:0];

    if (exp_r >= 8'sd31) begin
      y_o   = sign_i ? FP16_NEG_INF : FP16_POS_INF;
      ovf_o = 1'b1;
    end else begin
      y_o = {sign_i, exp_r[4:0], man_r};
    end

`ifdef FP16_MUL_DENORM_EN
    shamt = 8'sd1 - exp_i;
    sh    = '0;
    lost  = 1'b0;
    dg    = 1'b0;
    dr    = 1'b0;
    ds    = 1'b0;
    dinc  = 1'b0;
    drnd  = '0;
    if (exp_i < 8'sd1) begin
      if (shamt >= 8'sd12) begin
        // Leading one lands below the round bit: always rounds to zero.
        y_o   = {sign_i, 15'b0};
        unf_o = 1'b1;
      end else begin
        sh    = sig_i >> shamt[3:0];
        lost  = |(sig_i & ((13'd1 << shamt[3:0]) - 13'd1));
        dg    = sh[1];
        dr    = sh[0];
        ds    = sticky_i | lost;
        dinc  = dg & (dr | ds | sh[2]);
        drnd  = {1'b0, sh[12:2]} + {11'b0, dinc};
        // A carry into bit 10 becomes exponent field 1: the smallest normal.
        y_o   = {sign_i, 4'b0, drnd[10:0]};
        unf_o = dg | dr | ds;
      end
    end
`else
    if (exp_r < 8'sd1) begin
      y_o   = {sign_i, 15'b0};
      unf_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/fp16_mul.sv
// Single-stage registered FP16 multiplier, y = a * b, latency one cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fp16_mul_if.slave: in_valid/a/b in, out_valid/y/flag_inv/flag_ovf/flag_unf out
// Macro FP16_MUL_DENORM_EN: defined -> subnormal inputs/outputs, undefined -> flush to zero.
module fp16_mul
  import fp16_mul_pkg::*;
(
  input logic        clk,
  input logic        rst,
  fp16_mul_if.slave  bus
);

  logic              sign_y;
  logic [4:0]        ea, eb;
  logic [9:0]        ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [10:0]       sig_a, sig_b;
  logic [21:0]       prod, norm;
  logic [4:0]        lz;
  logic signed [7:0] exp_n;

  logic [15:0]       rp_y;
  logic              rp_ovf, rp_unf;

  logic [15:0]       res_y;
  logic              res_inv, res_ovf, res_unf;

  logic              out_valid_d, out_valid_q;
  logic [15:0]       y_d, y_q;
  logic              inv_d, inv_q, ovf_d, ovf_q, unf_d, unf_q;

  always_comb begin
    sign_y = fp16_sign(bus.a) ^ fp16_sign(bus.b);
    ea     = fp16_exp(bus.a);
    eb     = fp16_exp(bus.b);
    ma     = fp16_man(bus.a);
    mb     = fp16_man(bus.b);
    a_nan  = (&ea) & (|ma);
    b_nan  = (&eb) & (|mb);
    a_inf  = (&ea) & ~(|ma);
    b_inf  = (&eb) & ~(|mb);
`ifdef FP16_MUL_DENORM_EN
    a_zero = ~(|ea) & ~(|ma);
    b_zero = ~(|eb) & ~(|mb);
`else
    a_zero = ~(|ea);
    b_zero = ~(|eb);
`endif
    sig_a  = {|ea, ma};
    sig_b  = {|eb, mb};
    prod   = sig_a * sig_b;

    // Bring the leading one to bit 21; exponent tracks that position.
`ifdef FP16_MUL_DENORM_EN
    lz     = lzc22(prod);
    norm   = prod << lz;
`else
    lz     = prod[21] ? 5'd0 : 5'd1;
    norm   = prod[21] ? prod : (prod << 1);
`endif
    // Subnormal operands use exponent 1.
    exp_n  = $signed({3'b0, (|ea) ? ea : 5'd1}) + $signed({3'b0, (|eb) ? eb : 5'd1})
           - BIAS_S + 8'sd1 - $signed({3'b0, lz});
  end

  fp16_round_pack u_round_pack (
    .sign_i   (sign_y),
    .exp_i    (exp_n),
    .sig_i    (norm[21:9]),
    .sticky_i (|norm[8:0]),
    .y_o      (rp_y),
    .ovf_o    (rp_ovf),
    .unf_o    (rp_unf)
  );

  always_comb begin
    res_y   = rp_y;
    res_inv = 1'b0;
    res_ovf = rp_ovf;
    res_unf = rp_unf;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res_y   = FP16_QNAN;
      res_inv = 1'b1;
      res_ovf = 1'b0;
      res_unf = 1'b0;
    end else if (a_inf || b_inf) begin
      res_y   = sign_y ? FP16_NEG_INF : FP16_POS_INF;
      res_ovf = 1'b0;
      res_unf = 1'b0;
    end else if (a_zero || b_zero) begin
      res_y   = sign_y ? FP16_NEG_ZERO : FP16_POS_ZERO;
      res_ovf = 1'b0;
      res_unf = 1'b0;
    end

    out_valid_d = bus.in_valid;
    y_d         = bus.in_valid ? res_y   : y_q;
    inv_d       = bus.in_valid ? res_inv : inv_q;
    ovf_d       = bus.in_valid ? res_ovf : ovf_q;
    unf_d       = bus.in_valid ? res_unf : unf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= FP16_POS_ZERO;
      inv_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      inv_q       <= inv_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.flag_inv  = inv_q;
  assign bus.flag_ovf  = ovf_q;
  assign bus.flag_unf  = unf_q;

endmodule

// File: tb/tb_fp16_mul.sv
// Directed, table-driven bench for fp16_mul (both FP16_MUL_DENORM_EN builds).
module tb_fp16_mul;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        inv;
    logic        ovf;
    logic        unf;
  } vec_t;

  localparam int NV = 20;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs [NV];

  fp16_mul_if bus ();

  fp16_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string what, input int idx, input logic [15:0] act,
                       input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", what, idx, act, req);
    end
  endtask

  task automatic check_vec(input string what, input int idx, input vec_t v);
    check({what, ".y"}, idx, bus.y, v.y);
    check({what, ".vflags"}, idx,
          {12'b0, bus.out_valid, bus.flag_inv, bus.flag_ovf, bus.flag_unf},
          {12'b0, 1'b1, v.inv, v.ovf, v.unf});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{16'h3C00, 16'h4200, 16'h4200, 1'b0, 1'b0, 1'b0}; // 1 * 3
    vecs[1]  = '{16'h4000, 16'h3800, 16'h3C00, 1'b0, 1'b0, 1'b0}; // 2 * 0.5
    vecs[2]  = '{16'h4200, 16'h3A00, 16'h4080, 1'b0, 1'b0, 1'b0}; // 3 * 0.75 = 2.25
    vecs[3]  = '{16'h4200, 16'h3D00, 16'h4380, 1'b0, 1'b0, 1'b0}; // 3 * 1.25 = 3.75
    vecs[4]  = '{16'hBC00, 16'h4000, 16'hC000, 1'b0, 1'b0, 1'b0}; // sign
    vecs[5]  = '{16'h3C01, 16'h3E00, 16'h3E02, 1'b0, 1'b0, 1'b0}; // tie, odd lsb rounds up
    vecs[6]  = '{16'h3C01, 16'h3C01, 16'h3C02, 1'b0, 1'b0, 1'b0}; // below half, truncates
    vecs[7]  = '{16'h0000, 16'h4300, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'h4200, 16'h8000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h7C00, 16'h4380, 16'h7C00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'hFC00, 16'h3800, 16'hFC00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h7C00, 16'h0000, 16'h7E00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{16'h7E01, 16'h3C00, 16'h7E00, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{16'h8000, 16'hFC00, 16'h7E00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{16'h7BFF, 16'h4000, 16'h7C00, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{16'hFBFF, 16'h4000, 16'hFC00, 1'b0, 1'b1, 1'b0};
`ifdef FP16_MUL_DENORM_EN
    vecs[16] = '{16'h0001, 16'h4000, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{16'h0001, 16'h3800, 16'h0000, 1'b0, 1'b0, 1'b1}; // exact half, ties to 0
    vecs[18] = '{16'h0400, 16'h3800, 16'h0200, 1'b0, 1'b0, 1'b0}; // exact subnormal
    vecs[19] = '{16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b0, 1'b1}; // far below, shift >= 12
`else
    vecs[16] = '{16'h0001, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0}; // input flushed
    vecs[17] = '{16'h8001, 16'h3800, 16'h8000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{16'h0400, 16'h3800, 16'h0000, 1'b0, 1'b0, 1'b1}; // result flushed
    vecs[19] = '{16'h8400, 16'h0400, 16'h8000, 1'b0, 1'b0, 1'b1};
`endif

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0;
    bus.b        = 16'h0;
    #1;
    check("reset.y", 0, bus.y, 16'h0000);
    check("reset.vflags", 0, {12'b0, bus.out_valid, bus.flag_inv, bus.flag_ovf, bus.flag_unf},
          16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back issue; each result appears one cycle after its operands.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      @(posedge clk);
      #1;
      check_vec("vec", i, vecs[i]);
    end

    // Idle cycle: out_valid drops, y and flags hold the last result.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 16'h4000;
    bus.b        = 16'h4000;
    @(posedge clk);
    #1;
    check("hold.valid", 0, {15'b0, bus.out_valid}, 16'h0);
    check("hold.y", 0, bus.y, vecs[NV-1].y);

    // Four-deep stream after a gap, order preserved.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = vecs[i + 4].a;
      bus.b        = vecs[i + 4].b;
      @(posedge clk);
      #1;
      check_vec("stream", i, vecs[i + 4]);
    end

    // Asynchronous reset between edges while out_valid is high.
    @(negedge clk);
    bus.a = 16'h3C00;
    bus.b = 16'h4200;
    @(posedge clk);
    #1;
    check("pre_rst.valid", 0, {15'b0, bus.out_valid}, 16'h1);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.valid", 0, {15'b0, bus.out_valid}, 16'h0);
    check("async_rst.y", 0, bus.y, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.valid", 0, {15'b0, bus.out_valid}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
